multicycle_control_unit: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS control decoder: a Moore/Mealy FSM that sequences each instruction over 3–5 cycles on a shared ALU and a unified instruction/data memory.
- Supports the same opcode set as the single-cycle decoder: R-type, ADDI, BEQ, J, LW and SW.
- New capabilities: a memory ready handshake with a wait-state timeout, an enable/stall input, a per-instruction done pulse, and a sticky trap on illegal opcode or memory timeout.
- Sits between the instruction register opcode field and the multi-cycle datapath muxes and enables.

---
 rtl/control_pkg.sv | 71 +++++++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/multicycle_control_unit.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU ops,
// datapath mux selects, trap causes, FSM states and the control bundle.
package control_pkg;

  localparam logic [5:0] ALU_R      = 6'h00;
  localparam logic [5:0] ADDI       = 6'h08;
  localparam logic [5:0] BRANCH_EQ  = 6'h04;
  localparam logic [5:0] JUMP       = 6'h02;
  localparam logic [5:0] LOAD_WORD  = 6'h23;
  localparam logic [5:0] STORE_WORD = 6'h2B;

  localparam logic [1:0] ADD    = 2'd0;
  localparam logic [1:0] SUB    = 2'd1;
  localparam logic [1:0] R_TYPE = 2'd2;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } trap_cause_e;

  typedef enum logic [3:0] {
    S_FETCH_IDLE = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC       = 4'd3,
    S_ALU_WB     = 4'd4,
    S_ADDI_EX    = 4'd5,
    S_ADDI_WB    = 4'd6,
    S_BRANCH     = 4'd7,
    S_JUMP       = 4'd8,
    S_MEM_ADDR   = 4'd9,
    S_MEM_RD     = 4'd10,
    S_MEM_WB     = 4'd11,
    S_MEM_WR     = 4'd12,
    S_TRAP       = 4'd13
  } state_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_dst;
    logic       mem_2_reg;
    logic       reg_write;
    logic       instr_done;
    logic       trap;
  } ctrl_t;

  // States that hold a memory request open and are guarded by the wait timer.
  function automatic logic is_mem_state(state_e s);
    return s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait-state counter for one memory access; flags when the count
// reaches MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int CNT_W       = 8,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (cnt_q == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences R-type/ADDI/BEQ/J/LW/SW over a shared
// ALU and unified memory, with wait-state timeout and a sticky trap.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALU_OP_W    = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                reg_dst,
  output logic                mem_2_reg,
  output logic                reg_write,
  output logic                instr_done,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output state_e              state_o
);

  state_e      state_q, state_d;
  trap_cause_e cause_q, cause_d;
  ctrl_t       ctrl, ctrl_out;
  logic        in_mem, timeout;

  // Memory handshake: mem_read/mem_write stay high every cycle of a memory
  // state; the access completes in the cycle mem_ready is sampled high.
  assign in_mem = is_mem_state(state_q);

  mem_wait_timer #(
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk_i    (clk),
    .rst_n_i  (arst_n),
    .clr_i    (!in_mem || mem_ready),
    .en_i     (in_mem && !mem_ready),
    .timeout_o(timeout)
  );

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= S_FETCH_IDLE;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ctrl    = '0;
    unique case (state_q)
      S_FETCH_IDLE: begin
        if (en) state_d = S_FETCH;
      end
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ADD;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_op    = ADD;
        if (opcode == OPCODE_W'(ALU_R)) begin
          state_d = S_EXEC;
        end else if (opcode == OPCODE_W'(ADDI)) begin
          state_d = S_ADDI_EX;
        end else if (opcode == OPCODE_W'(BRANCH_EQ)) begin
          state_d = S_BRANCH;
        end else if (opcode == OPCODE_W'(JUMP)) begin
          state_d = S_JUMP;
        end else if ((opcode == OPCODE_W'(LOAD_WORD)) || (opcode == OPCODE_W'(STORE_WORD))) begin
          state_d = S_MEM_ADDR;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = R_TYPE;
        state_d        = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH_IDLE;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ADD;
        state_d        = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH_IDLE;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
        state_d            = S_FETCH_IDLE;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_SRC_JUMP;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH_IDLE;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ADD;
        state_d = (opcode == OPCODE_W'(LOAD_WORD)) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WB: begin
        ctrl.mem_2_reg  = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH_IDLE;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
        if (mem_ready) begin
          state_d = S_FETCH_IDLE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_TRAP: begin
        ctrl.trap = 1'b1;
      end
      default: begin
        state_d = S_FETCH_IDLE;
      end
    endcase
  end

  // Reset is held combinationally over every output, including debug state.
  assign ctrl_out      = arst_n ? ctrl : '0;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign i_or_d        = ctrl_out.i_or_d;
  assign ir_write      = ctrl_out.ir_write;
  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign pc_source     = ctrl_out.pc_source;
  assign alu_op        = ALU_OP_W'(ctrl_out.alu_op);
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign reg_dst       = ctrl_out.reg_dst;
  assign mem_2_reg     = ctrl_out.mem_2_reg;
  assign reg_write     = ctrl_out.reg_write;
  assign instr_done    = ctrl_out.instr_done;
  assign trap          = ctrl_out.trap;
  assign trap_cause    = arst_n ? cause_q : CAUSE_NONE;
  assign state_o       = arst_n ? state_q : S_FETCH_IDLE;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: an instruction-level model expands each
// instruction into its per-cycle state/strobe sequence and a compare process checks every cycle.
module tb_multicycle_control_unit;
  import control_pkg::*;

  localparam int TB_TIMEOUT = 4;
  localparam int TRAP_HOLD  = 20;

  logic        clk = 1'b0;
  logic        arst_n, en, mem_ready;
  logic [5:0]  opcode;
  logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_source, alu_op, alu_src_b, trap_cause;
  logic        alu_src_a, reg_dst, mem_2_reg, reg_write, instr_done, trap;
  state_e      state_o;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .OPCODE_W(6), .ALU_OP_W(2), .MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(8)
  ) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_dst(reg_dst),
    .mem_2_reg(mem_2_reg), .reg_write(reg_write), .instr_done(instr_done),
    .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  typedef struct packed {
    state_e     st;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_dst, mem_2_reg, reg_write, instr_done, trap;
    logic [1:0] trap_cause;
  } out_t;

  typedef struct packed {
    logic       rst;
    state_e     st;
    logic       en;
    logic       rdy;
    logic [1:0] cause;
  } step_t;

  localparam int OUT_W = $bits(out_t);

  logic [OUT_W-1:0] exp_q[$];
  step_t            plan_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int lat_cnt = 0, last_lat = 0, done_cnt = 0;
  int mr_cyc = 0, rd_cyc = 0, wr_cyc = 0, regw_cyc = 0, trap_cyc = 0;

  // ---------------- model: instruction -> per-cycle steps ----------------
  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void add_step(state_e st, logic en_v, logic rdy_v, logic [1:0] cause);
    step_t s;
    s.rst = 1'b0; s.st = st; s.en = en_v; s.rdy = rdy_v; s.cause = cause;
    plan_q.push_back(s);
  endfunction

  function automatic void add_any(state_e st);
    add_step(st, rnd_bit(), rnd_bit(), 2'd0);
  endfunction

  function automatic void add_reset(int n);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s = '0;
      s.rst = 1'b1; s.en = rnd_bit(); s.rdy = rnd_bit();
      plan_q.push_back(s);
    end
  endfunction

  function automatic void add_trap(logic [1:0] cause, int n);
    for (int i = 0; i < n; i++) add_step(S_TRAP, rnd_bit(), rnd_bit(), cause);
  endfunction

  // A memory access of `waits` stalled cycles; returns 1 if it times out.
  function automatic bit add_mem(state_e st, int waits);
    for (int i = 0; i <= waits; i++) begin
      add_step(st, rnd_bit(), (i == waits), 2'd0);
      if (i == TB_TIMEOUT && i != waits) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void plan_instr(logic [5:0] op, int fw, int mw);
    add_step(S_FETCH_IDLE, 1'b1, rnd_bit(), 2'd0);
    if (add_mem(S_FETCH, fw)) begin
      add_trap(2'd2, TRAP_HOLD);
      return;
    end
    add_any(S_DECODE);
    case (op)
      6'h00: begin add_any(S_EXEC); add_any(S_ALU_WB); end
      6'h08: begin add_any(S_ADDI_EX); add_any(S_ADDI_WB); end
      6'h04: add_any(S_BRANCH);
      6'h02: add_any(S_JUMP);
      6'h23: begin
        add_any(S_MEM_ADDR);
        if (add_mem(S_MEM_RD, mw)) add_trap(2'd2, TRAP_HOLD);
        else add_any(S_MEM_WB);
      end
      6'h2B: begin
        add_any(S_MEM_ADDR);
        if (add_mem(S_MEM_WR, mw)) add_trap(2'd2, TRAP_HOLD);
      end
      default: add_trap(2'd1, TRAP_HOLD);
    endcase
  endfunction

  // Output table per state, numeric encodings straight from the datasheet.
  function automatic out_t model_out(step_t s);
    out_t o;
    o = '0;
    if (!s.rst) begin
      o.st = s.st;
      case (s.st)
        S_FETCH:    begin o.mem_read = 1; o.alu_src_b = 2'd1; o.ir_write = s.rdy; o.pc_write = s.rdy; end
        S_DECODE:   o.alu_src_b = 2'd3;
        S_EXEC:     begin o.alu_src_a = 1; o.alu_op = 2'd2; end
        S_ALU_WB:   begin o.reg_dst = 1; o.reg_write = 1; o.instr_done = 1; end
        S_ADDI_EX:  begin o.alu_src_a = 1; o.alu_src_b = 2'd2; end
        S_ADDI_WB:  begin o.reg_write = 1; o.instr_done = 1; end
        S_BRANCH:   begin o.alu_src_a = 1; o.alu_op = 2'd1; o.pc_write_cond = 1; o.pc_source = 2'd1; o.instr_done = 1; end
        S_JUMP:     begin o.pc_write = 1; o.pc_source = 2'd2; o.instr_done = 1; end
        S_MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'd2; end
        S_MEM_RD:   begin o.mem_read = 1; o.i_or_d = 1; end
        S_MEM_WB:   begin o.mem_2_reg = 1; o.reg_write = 1; o.instr_done = 1; end
        S_MEM_WR:   begin o.mem_write = 1; o.i_or_d = 1; o.instr_done = s.rdy; end
        S_TRAP:     begin o.trap = 1; o.trap_cause = s.cause; end
        default: ;
      endcase
    end
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic run_plan(logic [5:0] op);
    step_t s;
    opcode = op;
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      @(posedge clk); #1;
      arst_n    = !s.rst;
      en        = s.en;
      mem_ready = s.rdy;
      exp_q.push_back(model_out(s));
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic clear_obs();
    done_cnt = 0; mr_cyc = 0; rd_cyc = 0; wr_cyc = 0; regw_cyc = 0; trap_cyc = 0; last_lat = 0;
  endtask

  task automatic check_int(string name, int act, int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic do_instr(logic [5:0] op, int fw, int mw);
    clear_obs();
    plan_instr(op, fw, mw);
    run_plan(op);
    settle();
  endtask

  // ---------------- compare process + observers ----------------
  initial begin
    out_t             act;
    logic [OUT_W-1:0] act_v, exp_v;
    int               step_no;
    step_no = 0;
    forever begin
      @(negedge clk);
      act.st = state_o;
      act.mem_read = mem_read; act.mem_write = mem_write; act.i_or_d = i_or_d;
      act.ir_write = ir_write; act.pc_write = pc_write; act.pc_write_cond = pc_write_cond;
      act.pc_source = pc_source; act.alu_op = alu_op; act.alu_src_a = alu_src_a;
      act.alu_src_b = alu_src_b; act.reg_dst = reg_dst; act.mem_2_reg = mem_2_reg;
      act.reg_write = reg_write; act.instr_done = instr_done; act.trap = trap;
      act.trap_cause = trap_cause;
      act_v = act;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        step_no++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL cycle_outputs step %0d: got %h expected %h (state got %0d expected %0d)",
                   step_no, act_v, exp_v, act_v[OUT_W-1 -: 4], exp_v[OUT_W-1 -: 4]);
        end
      end
      if (!arst_n || state_o == S_FETCH_IDLE) lat_cnt = 0;
      else lat_cnt++;
      if (instr_done) begin last_lat = lat_cnt; done_cnt++; end
      if (mem_read) mr_cyc++;
      if (mem_read && i_or_d) rd_cyc++;
      if (mem_write) wr_cyc++;
      if (reg_write) regw_cyc++;
      if (trap) trap_cyc++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    arst_n = 1'b0; en = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
    repeat (2) @(posedge clk);
    add_reset(2);
    run_plan(6'h00);

    // en low: stays idle, no fetch
    clear_obs();
    for (int i = 0; i < 10; i++) add_step(S_FETCH_IDLE, 1'b0, rnd_bit(), 2'd0);
    run_plan(6'h00);
    settle();
    check_int("idle_no_mem_read", mr_cyc, 0);

    do_instr(6'h04, 0, 0);
    check_int("beq_latency", last_lat, 3);
    check_int("beq_done_pulses", done_cnt, 1);

    do_instr(6'h00, 0, 0);
    check_int("rtype_latency", last_lat, 4);
    check_int("rtype_reg_write_cycles", regw_cyc, 1);

    do_instr(6'h08, 1, 0);
    check_int("addi_latency_1wait", last_lat, 5);

    do_instr(6'h02, 2, 0);
    check_int("jump_latency_2wait", last_lat, 5);

    do_instr(6'h23, 0, 3);
    check_int("lw_latency_3wait", last_lat, 8);
    check_int("lw_data_read_cycles", rd_cyc, 4);

    do_instr(6'h2B, 0, 0);
    check_int("sw_latency", last_lat, 4);
    check_int("sw_write_cycles", wr_cyc, 1);
    check_int("sw_no_reg_write", regw_cyc, 0);

    do_instr(6'h2B, 0, 2);
    check_int("sw_latency_2wait", last_lat, 6);

    // ready arrives exactly on the timeout cycle: no trap
    do_instr(6'h00, TB_TIMEOUT, 0);
    check_int("fetch_boundary_latency", last_lat, 8);
    check_int("fetch_boundary_no_trap", trap_cyc, 0);

    // fetch timeout
    do_instr(6'h00, TB_TIMEOUT + 1, 0);
    check_int("fetch_timeout_trap_cycles", trap_cyc, TRAP_HOLD);
    check_int("fetch_timeout_no_done", done_cnt, 0);
    add_reset(1);
    run_plan(6'h00);

    // load data timeout
    do_instr(6'h23, 0, TB_TIMEOUT + 1);
    check_int("lw_timeout_trap_cycles", trap_cyc, TRAP_HOLD);
    add_reset(1);
    run_plan(6'h00);

    // illegal opcode, then one reset edge and a clean instruction
    do_instr(6'h3F, 0, 0);
    check_int("illegal_trap_cycles", trap_cyc, TRAP_HOLD);
    check_int("illegal_no_mem_read_after_fetch", mr_cyc, 1);
    add_reset(1);
    run_plan(6'h00);

    do_instr(6'h23, 1, 0);
    check_int("lw_after_reset_latency", last_lat, 6);
    check_int("lw_after_reset_no_trap", trap_cyc, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
